pcr_host_access_ctrl: RTL
=========================

// Module: pcr_host_access_ctrl
// PURPOSE
//  Shares the single PCR read port and single write port between the core pipeline and
//  host (HTIF) debug accesses. Core traffic has priority; host requests wait for an idle
//  port slot. A starvation counter stalls the core once the wait reaches a limit.
//  Sits between the pipeline control, the HTIF, and the PCR register file.
// PARAMETERS
//  STARVE_LIMIT  15  cycles a host request may wait in WAIT before core_stall is raised (1..2^CNT_W-1)
//  CNT_W         4   width of the starvation counter
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high reset
//  host_req_val    in   1   host request valid
//  host_req_rdy    out  1   controller can accept a request (high only in IDLE)
//  host_req_rw     in   1   1 = write, 0 = read
//  host_req_addr   in   5   PCR address
//  host_req_wdata  in   64  write data
//  host_resp_val   out  1   response valid
//  host_resp_rdy   in   1   host accepts the response
//  host_resp_data  out  64  read data; 0 for writes
//  core_ren        in   1   core PCR read this cycle
//  core_raddr      in   5   core read address
//  core_rdata      out  64  core_ren ? pcr_rdata : 0
//  core_wen        in   1   core PCR write this cycle
//  core_waddr      in   5   core write address
//  core_wdata      in   64  core write data
//  core_exception  in   1   exception commits this cycle (changes PCR state)
//  core_eret       in   1   eret commits this cycle (changes PCR state)
//  core_stall      out  1   registered request to pipeline: hold off PCR ren/wen
//  pcr_ren         out  1   to PCR file
//  pcr_raddr       out  5   to PCR file
//  pcr_rdata       in   64  from PCR file (combinational)
//  pcr_wen         out  1   to PCR file
//  pcr_waddr       out  5   to PCR file
//  pcr_wdata       out  64  to PCR file
// BEHAVIOUR
//  - States: IDLE, WAIT, RESP. On reset: state=IDLE, host_req_rdy=1, host_resp_val=0,
//    host_resp_data=0, core_stall=0, starve counter=0, captured request cleared.
//  - IDLE: host_req_val && host_req_rdy captures rw/addr/wdata -> WAIT. No port access in
//    the capture cycle.
//  - WAIT, read: grant when !core_ren. In the grant cycle: pcr_ren=1, pcr_raddr=captured
//    addr, and pcr_rdata is registered into host_resp_data -> RESP.
//  - WAIT, write: grant when !core_wen && !core_exception && !core_eret. In the grant cycle:
//    pcr_wen=1, pcr_waddr/pcr_wdata=captured values, host_resp_data<=0 -> RESP.
//  - Not granted: the PCR ports pass the core signals through unchanged, and the counter
//    increments, saturating at 2^CNT_W-1.
//  - Minimum latency: capture in cycle N, grant in N+1, host_resp_val high in N+2.
//  - RESP: host_resp_val=1 and host_resp_data is held stable until host_resp_rdy.
//    On that handshake -> IDLE; a new request is accepted no earlier than the next cycle.
//  - Starvation: core_stall is set on the clock edge where the counter reaches STARVE_LIMIT
//    while in WAIT. It clears on the edge that leaves WAIT, and the counter resets to 0 on
//    grant. While core_stall=1 the pipeline guarantees core_ren=core_wen=0.
//    core_exception and core_eret still block a host write.
//  - The core never loses an access. A host access is issued only in a slot the core
//    leaves free, so the write port is never double-driven.
//  - A core write and a host read in the same cycle are allowed (separate ports). Host read
//    data reflects PCR state before that edge.
//  - Reset mid-operation, in any state: the pending request or response is discarded, no
//    PCR write is issued, and state=IDLE.
// TESTING
//  - Idle core, host read addr 1 (EPC=0x1000): resp_val in cycle N+2, data=0x1000, no pcr_wen.
//  - Host write K0=0xDEAD_BEEF while core_wen is high 3 cycles: pcr_wen(host) on the 4th
//    cycle, a later read returns 0xDEADBEEF, and all core writes land.
//  - core_ren held high continuously with a host read pending: core_stall rises after 15 WAIT
//    cycles. Core drops ren, grant follows, stall falls, and the response is correct.
//  - Host write pending coincident with core_exception or core_eret: no grant that cycle,
//    grant the next free cycle.
//  - host_resp_rdy low 5 cycles: resp_val/data stable, req_rdy=0, and a 2nd host_req_val
//    is not accepted until after the handshake.
//  - Reset asserted in WAIT with a write pending: no pcr_wen, and outputs return to reset values.

Source files
------------

// File: rtl/pcr_host_access_ctrl.sv
// Arbitrates the PCR read/write ports between the core pipeline (priority) and
// host debug requests, stalling the core when a host request starves too long.
module pcr_host_access_ctrl #(
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_req_val,
  output logic        host_req_rdy,
  input  logic        host_req_rw,
  input  logic [4:0]  host_req_addr,
  input  logic [63:0] host_req_wdata,
  output logic        host_resp_val,
  input  logic        host_resp_rdy,
  output logic [63:0] host_resp_data,
  input  logic        core_ren,
  input  logic [4:0]  core_raddr,
  output logic [63:0] core_rdata,
  input  logic        core_wen,
  input  logic [4:0]  core_waddr,
  input  logic [63:0] core_wdata,
  input  logic        core_exception,
  input  logic        core_eret,
  output logic        core_stall,
  output logic        pcr_ren,
  output logic [4:0]  pcr_raddr,
  input  logic [63:0] pcr_rdata,
  output logic        pcr_wen,
  output logic [4:0]  pcr_waddr,
  output logic [63:0] pcr_wdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic             rw_q, rw_d;
  logic [4:0]       addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic             grant;

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    grant       = 1'b0;
    pcr_ren     = core_ren;
    pcr_raddr   = core_raddr;
    pcr_wen     = core_wen;
    pcr_waddr   = core_waddr;
    pcr_wdata   = core_wdata;

    case (state_q)
      IDLE: begin
        if (host_req_val) begin
          rw_d    = host_req_rw;
          addr_d  = host_req_addr;
          wdata_d = host_req_wdata;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Gated by reset so a pending write is never issued during a reset cycle.
        grant = !reset && (rw_q ? (!core_wen && !core_exception && !core_eret) : !core_ren);
        if (grant) begin
          if (rw_q) begin
            pcr_wen     = 1'b1;
            pcr_waddr   = addr_q;
            pcr_wdata   = wdata_q;
            resp_data_d = '0;
          end else begin
            pcr_ren     = 1'b1;
            pcr_raddr   = addr_q;
            resp_data_d = pcr_rdata;
          end
          cnt_d   = '0;
          stall_d = 1'b0;
          state_d = RESP;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d >= LIMIT) stall_d = 1'b1;
        end
      end
      RESP: begin
        if (host_resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign host_req_rdy   = (state_q == IDLE);
  assign host_resp_val  = (state_q == RESP);
  assign host_resp_data = resp_data_q;
  assign core_stall     = stall_q;
  assign core_rdata     = core_ren ? pcr_rdata : '0;

endmodule
